// File: rtl/calc_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_cmd_scheduler_if
// Brief    : req/ack command channel between the scheduler and the ALU
// Revision : 1.0 - initial release
// ============================================================================
interface calc_cmd_scheduler_if;
  logic        alu_req;
  logic [2:0]  alu_op;
  logic [15:0] alu_operand;
  logic        alu_ack;
  logic        alu_err;
  logic [15:0] alu_result;

  modport master (
    output alu_req, alu_op, alu_operand,
    input  alu_ack, alu_err, alu_result
  );

  modport slave (
    input  alu_req, alu_op, alu_operand,
    output alu_ack, alu_err, alu_result
  );
endinterface
`default_nettype wire

// File: rtl/calc_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : calc_cmd_scheduler
// Brief    : button debounce, press capture, priority queueing and ALU issue
// Revision : 1.0 - initial release
// ============================================================================
module calc_cmd_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_DIV       = 33554432,
  parameter int BLINK_TOGGLES   = 10,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 sw,
  input  logic                        btnC,
  input  logic                        btnD,
  input  logic                        btnU,
  input  logic                        btnL,
  input  logic                        btnR,
  calc_cmd_scheduler_if.master        alu,
  output logic [15:0]                 led,
  output logic                        busy,
  output logic                        err_active
);
  localparam int NBTN  = 5;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W  = $clog2(BLINK_DIV + 1);
  localparam int TG_W  = $clog2(BLINK_TOGGLES + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0]  BL_LAST   = BL_W'(BLINK_DIV - 1);
  localparam logic [TG_W-1:0]  TG_LAST   = TG_W'(BLINK_TOGGLES - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [NBTN-1:0]   w_raw, r_deb, w_press, r_pend, w_accept, w_clr;
  logic [DB_W-1:0]   r_db_cnt [NBTN];
  logic [15:0]       r_slot   [NBTN];
  logic [2:0]        w_sel;
  logic              w_push, w_pop, w_flush, w_full, w_tick;
  logic [2:0]        r_fifo_op  [FIFO_DEPTH];
  logic [15:0]       r_fifo_opd [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr, r_rd;
  logic [CNT_W-1:0]  r_count;
  logic [BL_W-1:0]   r_blink_cnt;
  logic [TG_W-1:0]   r_toggles;

  // Bit index doubles as opcode: C=LOAD .. R=DIV, lowest index wins arbitration
  assign w_raw = {btnR, btnL, btnU, btnD, btnC};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < NBTN; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (w_raw[i] != r_deb[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_deb[i]    <= w_raw[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_press = '0;
    for (int i = 0; i < NBTN; i++)
      w_press[i] = w_raw[i] & ~r_deb[i] & (r_db_cnt[i] == DB_LAST);
  end

  always_comb begin
    w_sel = '0;
    for (int i = NBTN - 1; i >= 0; i--)
      if (r_pend[i]) w_sel = 3'(i);
  end

  assign w_full   = (r_count == FIFO_FULL);
  assign w_push   = (|r_pend) && !w_full && (r_state != S_ERR);
  assign w_accept = w_press & ~r_pend & {NBTN{r_state != S_ERR}};
  assign w_clr    = w_push ? (NBTN'(1) << w_sel) : '0;

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_accept;
    end
    if (rst) begin
      for (int i = 0; i < NBTN; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++)
        if (w_accept[i]) r_slot[i] <= sw;
    end
  end

  // Pointer wrap relies on FIFO_DEPTH being a power of two
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_op[r_wr]  <= w_sel;
        r_fifo_opd[r_wr] <= r_slot[w_sel];
        r_wr             <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    w_tick  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (alu.alu_ack) begin
          if (alu.alu_err) begin
            w_flush = 1'b1;
            w_next  = S_ERR;
          end else begin
            w_next  = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (r_blink_cnt == BL_LAST) begin
          w_tick = 1'b1;
          if (r_toggles == TG_LAST) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu.alu_req     <= 1'b0;
      alu.alu_op      <= '0;
      alu.alu_operand <= '0;
      led             <= '0;
      r_blink_cnt     <= '0;
      r_toggles       <= '0;
    end else begin
      if (w_pop) begin
        alu.alu_req     <= 1'b1;
        alu.alu_op      <= r_fifo_op[r_rd];
        alu.alu_operand <= r_fifo_opd[r_rd];
      end else if (r_state == S_ISSUE && alu.alu_ack) begin
        alu.alu_req <= 1'b0;
        if (!alu.alu_err) led <= alu.alu_result;
      end
      // An even number of inversions leaves the last good value on the display
      if (w_flush) begin
        r_blink_cnt <= '0;
        r_toggles   <= '0;
      end else if (r_state == S_ERR) begin
        if (w_tick) begin
          r_blink_cnt <= '0;
          r_toggles   <= r_toggles + TG_W'(1);
          led         <= ~led;
        end else begin
          r_blink_cnt <= r_blink_cnt + BL_W'(1);
        end
      end
    end
  end

  assign busy       = (r_count != '0) || (|r_pend) || (r_state != S_IDLE);
  assign err_active = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_calc_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_cmd_scheduler
// Brief    : self-checking bench with ALU responder and command-order model
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_cmd_scheduler;
  localparam int DB  = 4;
  localparam int BD  = 8;
  localparam int BT  = 10;
  localparam int DEP = 4;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] opd;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [15:0] led;
  logic        busy, err_active;

  calc_cmd_scheduler_if alu ();

  calc_cmd_scheduler #(
    .DEBOUNCE_CYCLES (DB),
    .BLINK_DIV       (BD),
    .BLINK_TOGGLES   (BT),
    .FIFO_DEPTH      (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btnC       (btn[0]),
    .btnD       (btn[1]),
    .btnU       (btn[2]),
    .btnL       (btn[3]),
    .btnR       (btn[4]),
    .alu        (alu.master),
    .led        (led),
    .busy       (busy),
    .err_active (err_active)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  cmd_t        exp_q[$];
  logic [15:0] exp_led = '0;
  int          stall_next = 0;
  bit          err_next = 1'b0;
  bit          use_ovr = 1'b0;
  logic [15:0] ovr_result = '0;
  bit          reset_hit = 1'b0;
  bit          resp_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Buttons pressed together are issued in C,D,U,L,R order
  function automatic void expect_mask(input logic [4:0] m, input logic [15:0] v);
    cmd_t c;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        c.op  = 3'(i);
        c.opd = v;
        exp_q.push_back(c);
      end
    end
  endfunction

  task automatic press(input logic [4:0] m, input logic [15:0] v, input bit accepted);
    @(negedge clk);
    sw  = v;
    btn = btn | m;
    if (accepted) expect_mask(m, v);
    repeat (DB + 2) @(negedge clk);
    btn = btn & ~m;
    repeat (DB + 2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || alu.alu_req || resp_busy) && n < 400);
    check(tag, {31'd0, busy || alu.alu_req || resp_busy}, 32'd0);
    check({tag, "_queue"}, exp_q.size(), 32'd0);
  endtask

  // ALU responder: checks each issued command against the expected order
  initial begin : g_responder
    cmd_t        e;
    logic [2:0]  g_op;
    logic [15:0] g_opd, res;
    bit          err;
    int          dly;
    alu.alu_ack    = 1'b0;
    alu.alu_err    = 1'b0;
    alu.alu_result = '0;
    forever begin
      @(posedge clk); #1;
      if (alu.alu_req === 1'b1 && rst === 1'b0) begin
        resp_busy = 1'b1;
        g_op  = alu.alu_op;
        g_opd = alu.alu_operand;
        if (exp_q.size() == 0) begin
          check("unexpected_req", {13'd0, g_op, g_opd}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("issue_op", {29'd0, g_op}, {29'd0, e.op});
          check("issue_operand", {16'd0, g_opd}, {16'd0, e.opd});
        end
        dly = (stall_next > 0) ? stall_next : int'($urandom_range(0, 4));
        stall_next = 0;
        repeat (dly) begin
          @(posedge clk); #1;
          if (!reset_hit)
            check("req_hold", {alu.alu_req, alu.alu_op, alu.alu_operand},
                  {1'b1, g_op, g_opd});
        end
        res = use_ovr ? ovr_result : 16'($urandom);
        use_ovr = 1'b0;
        err = err_next;
        err_next = 1'b0;
        alu.alu_ack    = 1'b1;
        alu.alu_err    = err;
        alu.alu_result = res;
        @(posedge clk); #1;
        alu.alu_ack = 1'b0;
        alu.alu_err = 1'b0;
        check("req_drop", {31'd0, alu.alu_req}, 32'd0);
        if (reset_hit) begin
          check("late_ack_led", {16'd0, led}, 32'd0);
          check("late_ack_busy", {31'd0, busy}, 32'd0);
          reset_hit = 1'b0;
        end else if (!err) begin
          exp_led = res;
          check("led_result", {16'd0, led}, {16'd0, exp_led});
        end else begin
          exp_q.delete();
          check("blink_entry_led", {16'd0, led}, {16'd0, exp_led});
          check("blink_entry_err", {31'd0, err_active}, 32'd1);
          for (int k = 1; k <= BD * BT; k++) begin
            @(posedge clk); #1;
            check("blink_led", {16'd0, led},
                  {16'd0, exp_led ^ ((((k / BD) % 2) == 1) ? 16'hFFFF : 16'h0000)});
            check("blink_err_active", {31'd0, err_active}, {31'd0, k < BD * BT});
          end
        end
        resp_busy = 1'b0;
      end
    end
  end

  initial begin : g_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : g_main
    int   lat, n;
    logic [4:0]  m;
    logic [15:0] v;
    rst = 1'b1;
    btn = '0;
    sw  = '0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, alu.alu_req}, 32'd0);
    check("rst_op", {29'd0, alu.alu_op}, 32'd0);
    check("rst_operand", {16'd0, alu.alu_operand}, 32'd0);
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_active", {31'd0, err_active}, 32'd0);
    rst = 1'b0;

    // Single LOAD and press-to-request latency
    @(negedge clk);
    sw = 16'h0012;
    btn[0] = 1'b1;
    expect_mask(5'b00001, 16'h0012);
    use_ovr = 1'b1;
    ovr_result = 16'h0012;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (alu.alu_req) lat = i;
    end
    check("t1_latency", lat, DB + 2);
    btn[0] = 1'b0;
    wait_idle("t1_idle");
    check("t1_led", {16'd0, led}, 32'h0012);

    // Bouncing button never reaches a stable run of DB samples
    @(negedge clk);
    sw = 16'h0ADD;
    for (int i = 0; i < 10; i++) begin
      btn[1] = ~btn[1];
      repeat (2) @(negedge clk);
    end
    check("t2_no_early_press", {31'd0, busy}, 32'd0);
    expect_mask(5'b00010, 16'h0ADD);
    btn[1] = 1'b1;
    repeat (DB + 2) @(negedge clk);
    btn[1] = 1'b0;
    repeat (DB + 2) @(negedge clk);
    wait_idle("t2_idle");

    // Stalled ALU: FIFO fills, later presses stay pending and resolve by priority
    stall_next = 50;
    press(5'b00001, 16'h1111, 1'b1);
    press(5'b00110, 16'h2222, 1'b1);
    press(5'b11000, 16'h3333, 1'b1);
    expect_mask(5'b00001, 16'h0007);
    expect_mask(5'b01000, 16'h0005);
    expect_mask(5'b10000, 16'h0003);
    @(negedge clk); btn[4] = 1'b1;
    @(negedge clk); btn[3] = 1'b1;
    @(negedge clk); btn[0] = 1'b1;
    @(negedge clk); sw = 16'h0003;
    @(negedge clk); sw = 16'h0005;
    @(negedge clk); sw = 16'h0007;
    repeat (3) @(negedge clk);
    check("t3_busy_stalled", {31'd0, busy}, 32'd1);
    btn = '0;
    repeat (DB + 2) @(negedge clk);
    wait_idle("t3_idle");

    // Error blink; a press during the blink is ignored
    use_ovr = 1'b1;
    ovr_result = 16'h00F0;
    press(5'b00001, 16'h00F0, 1'b1);
    wait_idle("t4_load_idle");
    check("t4_led_before", {16'd0, led}, 32'h00F0);
    err_next = 1'b1;
    press(5'b00010, 16'h0001, 1'b1);
    n = 0;
    while (!err_active && n < 50) begin @(negedge clk); n++; end
    check("t4_err_seen", {31'd0, err_active}, 32'd1);
    press(5'b00100, 16'h5555, 1'b0);
    n = 0;
    while (err_active && n < 200) begin @(negedge clk); n++; end
    check("t4_err_done", {31'd0, err_active}, 32'd0);
    check("t4_busy_after", {31'd0, busy}, 32'd0);
    wait_idle("t4_idle");
    check("t4_led_final", {16'd0, led}, 32'h00F0);

    // Randomized presses, each drained before the next
    for (int it = 0; it < 25; it++) begin
      m = 5'($urandom_range(1, 31));
      v = 16'($urandom);
      press(m, v, 1'b1);
      wait_idle("rand_idle");
    end

    // Reset while a command is outstanding
    @(negedge clk);
    sw = 16'hBEEF;
    btn[0] = 1'b1;
    expect_mask(5'b00001, 16'hBEEF);
    stall_next = 30;
    n = 0;
    while (!alu.alu_req && n < 40) begin @(negedge clk); n++; end
    check("t6_req_seen", {31'd0, alu.alu_req}, 32'd1);
    btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_hit = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_req", {31'd0, alu.alu_req}, 32'd0);
    check("t6_led", {16'd0, led}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_operand", {16'd0, alu.alu_operand}, 32'd0);
    n = 0;
    while (resp_busy && n < 60) begin @(negedge clk); n++; end
    check("t6_resp_done", {31'd0, resp_busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t6_req_after", {31'd0, alu.alu_req}, 32'd0);
    check("t6_led_after", {16'd0, led}, 32'd0);
    check("t6_busy_after", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/calc_cmd_scheduler.md
Name: calc_cmd_scheduler

Overview:
- Front-end sequencer for the switch/button calculator datapath.
- Debounces the five push-buttons and converts each press into an opcode plus a switch operand captured at the moment of the press.
- Arbitrates simultaneous presses, queues commands, and issues them one at a time to the arithmetic unit over a req/ack handshake.
- Owns the LED display, including the 10-toggle error blink sequence after an overflow or divide error.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (minimum 1).
- BLINK_DIV, 33554432, clock cycles between LED toggles during the error sequence (2^25).
- BLINK_TOGGLES, 10, number of LED inversions in one error sequence.
- FIFO_DEPTH, 4, command queue entries (power of 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sw  in  16  operand switches
- btnC btnD btnU btnL btnR  in  1 each  raw buttons: LOAD, ADD, SUB, MUL, DIV
- alu_req  out  1  command valid to the arithmetic unit
- alu_op  out  3  opcode: 0 LOAD, 1 ADD, 2 SUB, 3 MUL, 4 DIV
- alu_operand  out  16  operand captured at the press
- alu_ack  in  1  arithmetic unit accepted and completed the command (one-cycle pulse)
- alu_err  in  1  qualifies alu_ack: result overflowed or was invalid
- alu_result  in  16  result, valid with alu_ack
- led  out  16  display
- busy  out  1  FIFO non-empty, or any pending bit set, or state not IDLE
- err_active  out  1  high while in ERR_BLINK

Behaviour:
- Reset: every output is 0; FIFO empty; pending bits clear; debounced levels 0; counters 0; state IDLE.
- Debounce, per button:
  - A counter restarts whenever the raw input differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the raw value.
  - A debounced 0->1 transition is a press.
- Press capture:
  - A press sets that button's pending bit and latches sw into that button's operand slot in the same cycle.
  - A press on a button whose pending bit is already set is dropped; its slot is not overwritten.
  - Presses while err_active=1 are ignored.
- Arbitration:
  - Each cycle, if the FIFO is not full, the highest-priority pending bit is cleared and pushed with its operand.
  - Priority order: C > D > U > L > R.
  - If the FIFO is full, pending bits hold.
  - Simultaneous presses enqueue over successive cycles in priority order.
- FSM state IDLE:
  - If the FIFO is non-empty, pop the head and drive alu_req=1 with its op/operand on the next cycle; go to ISSUE.
- FSM state ISSUE:
  - alu_req, alu_op and alu_operand hold stable until alu_ack.
  - alu_ack with alu_err=0: led <= alu_result, alu_req <= 0, go to IDLE.
  - alu_ack with alu_err=1: alu_req <= 0, go to ERR_BLINK.
- FSM state ERR_BLINK:
  - On entry: flush the FIFO, clear all pending bits, zero the blink counters, err_active=1.
  - led holds its last good value, inverted every BLINK_DIV cycles.
  - After BLINK_TOGGLES inversions: led equals the pre-error value (even count), go to IDLE.
- Latency, with an idle machine and empty FIFO:
  - press at cycle t -> pending at t+1 -> FIFO at t+2 -> alu_req=1 at t+3.
- Concurrency:
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - alu_ack outside ISSUE is ignored.
- Reset mid-operation: rst in any state returns to the reset values on the next edge.
  - alu_req drops even if a command was outstanding; that command is lost.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4. sw=0x0012, raw btnC high for 6 cycles -> one LOAD; alu_op=0, alu_operand=0x0012, alu_req at press+3. ack with result 0x0012 -> led=0x0012.
- Bounce: btnD toggled every 2 cycles for 20 cycles, then held -> exactly one ADD issued, after the stable run.
- Simultaneous press, same cycle: btnR with sw=0x0003, btnL with sw=0x0005, btnC with sw=0x0007 -> issue order LOAD 0x0007, MUL 0x0005, DIV 0x0003.
- Stall alu_ack for 50 cycles: alu_req and op/operand stay constant throughout.
  - While stalled, 4 distinct presses fill the FIFO and a 5th stays pending.
  - After acks resume, all 5 issue.
- BLINK_DIV=8, led=0x00F0: ack with alu_err=1 -> led alternates 0xFF0F/0x00F0 every 8 cycles for 10 toggles.
  - A btnU press during the blink is ignored; the FIFO is empty afterward; final led=0x00F0; err_active drops.
- rst asserted while in ISSUE -> next cycle alu_req=0, led=0, busy=0; a late alu_ack produces no change.
